// File: rtl/pr_pkg.sv
// rtl/pr_pkg.sv - shared types for the differential alert link receiver.
package pr_pkg;

  typedef struct packed {
    logic alert_p;
    logic alert_n;
  } alert_tx_t;

  typedef struct packed {
    logic ack_p;
    logic ack_n;
  } alert_rx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HS_ACK = 2'd1,
    PAUSE  = 2'd2
  } alert_rx_state_e;

  typedef enum logic [1:0] {
    DecAsserted = 2'd0,
    DecReleased = 2'd1,
    DecIntegErr = 2'd2
  } alert_dec_e;

  localparam alert_tx_t AlertTxIdle = '{alert_p: 1'b0, alert_n: 1'b1};
  localparam alert_rx_t AlertRxIdle = '{ack_p: 1'b0, ack_n: 1'b1};
  localparam alert_rx_t AlertRxAck  = '{ack_p: 1'b1, ack_n: 1'b0};

  function automatic alert_dec_e decode_tx(input alert_tx_t tx);
    if (tx.alert_p == tx.alert_n) return DecIntegErr;
    return tx.alert_p ? DecAsserted : DecReleased;
  endfunction

endpackage

// File: rtl/alert_rx_lane.sv
// rtl/alert_rx_lane.sv - one alert lane: 2-flop sync, decode, handshake FSM, saturating counter.
module alert_rx_lane
  import pr_pkg::*;
#(
  parameter int CntW = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  alert_tx_t       alert_tx_i,
  input  logic            cnt_clr_i,
  output alert_rx_t       alert_rx_o,
  output logic            alert_o,
  output logic            integ_fail_o,
  output logic [CntW-1:0] alert_cnt_o
);

  alert_tx_t       sync1_q, sync2_q;
  alert_rx_state_e state_q, state_d;
  logic            alert_q, integ_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  alert_dec_e      dec;
  logic            accept;

  assign dec = decode_tx(sync2_q);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dec == DecAsserted) begin
          state_d = HS_ACK;
          accept  = 1'b1;
        end
      end
      HS_ACK: if (dec == DecReleased) state_d = PAUSE;
      // PAUSE lasts exactly one cycle so the sender always observes ack low.
      PAUSE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) cnt_d = '0;
    else if (accept && (cnt_q != '1)) cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= AlertTxIdle;
      sync2_q <= AlertTxIdle;
      state_q <= IDLE;
      alert_q <= 1'b0;
      integ_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= alert_tx_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      alert_q <= accept;
      integ_q <= (dec == DecIntegErr);
      cnt_q   <= cnt_d;
    end
  end

  assign alert_rx_o   = (state_q == HS_ACK) ? AlertRxAck : AlertRxIdle;
  assign alert_o      = alert_q;
  assign integ_fail_o = integ_q;
  assign alert_cnt_o  = cnt_q;

endmodule

// File: rtl/alert_rx_array.sv
// rtl/alert_rx_array.sv - array of independent alert receiver lanes sharing one counter clear.
module alert_rx_array
  import pr_pkg::*;
#(
  parameter int NumAlerts = 3,
  parameter int CntW      = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  alert_tx_t [NumAlerts-1:0]       alert_tx_i,
  output alert_rx_t [NumAlerts-1:0]       alert_rx_o,
  output logic      [NumAlerts-1:0]       alert_o,
  output logic      [NumAlerts-1:0]       integ_fail_o,
  input  logic                            cnt_clr_i,
  output logic [NumAlerts-1:0][CntW-1:0]  alert_cnt_o
);

  for (genvar i = 0; i < NumAlerts; i++) begin : g_lane
    alert_rx_lane #(
      .CntW(CntW)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .alert_tx_i  (alert_tx_i[i]),
      .cnt_clr_i   (cnt_clr_i),
      .alert_rx_o  (alert_rx_o[i]),
      .alert_o     (alert_o[i]),
      .integ_fail_o(integ_fail_o[i]),
      .alert_cnt_o (alert_cnt_o[i])
    );
  end

endmodule

// File: tb/tb_alert_rx_array.sv
// tb/tb_alert_rx_array.sv - self-checking bench for alert_rx_array.
module tb_alert_rx_array;
  import pr_pkg::*;

  localparam int N = 3;
  localparam int W = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  alert_tx_t [N-1:0]    tx;
  alert_rx_t [N-1:0]    rx;
  logic [N-1:0]         alert;
  logic [N-1:0]         fail;
  logic                 clr = 1'b0;
  logic [N-1:0][W-1:0]  cnt;

  int n_cmp = 0;
  int n_err = 0;

  alert_rx_array #(.NumAlerts(N), .CntW(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .alert_tx_i(tx), .alert_rx_o(rx),
    .alert_o(alert), .integ_fail_o(fail), .cnt_clr_i(clr), .alert_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] tx;
    logic [2:0] exp_alert;
    logic [2:0] exp_fail;
    logic [5:0] exp_ack;
  } vec_t;

  vec_t vecs[40];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tx = {N{AlertTxIdle}};
    clr = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] idle_ack();
    return {N{2'b01}};
  endfunction

  // Reference model state for the random phase.
  int        m_phase[N];   // 0 waiting, 1 acknowledged, 2 one-cycle pause
  int        m_cnt[N];
  logic [1:0] m_d0[N], m_d1[N];
  logic [N-1:0] m_alert, m_fail;
  logic [5:0]   m_ack;

  task automatic model_edge(input logic clr_in);
    for (int l = 0; l < N; l++) begin
      logic [1:0] v;
      v = m_d1[l];
      m_d1[l] = m_d0[l];
      m_d0[l] = tx[l];
      m_alert[l] = 1'b0;
      m_fail[l] = (v[1] == v[0]);
      if (m_phase[l] == 2) m_phase[l] = 0;
      else if (!m_fail[l]) begin
        if (m_phase[l] == 0 && v == 2'b10) begin
          m_phase[l] = 1;
          m_alert[l] = 1'b1;
        end else if (m_phase[l] == 1 && v == 2'b01) m_phase[l] = 2;
      end
      if (clr_in) m_cnt[l] = 0;
      else if (m_alert[l] && m_cnt[l] < (1 << W) - 1) m_cnt[l] = m_cnt[l] + 1;
      m_ack[2*l +: 2] = (m_phase[l] == 1) ? 2'b10 : 2'b01;
    end
  endtask

  initial begin
    logic [1:0] hold_val[N];
    int         hold_cnt[N];
    logic       clr_prev;

    // Directed table: lane1 handshake (rows 0..19), lane0 integrity error (rows 20..39).
    for (int c = 0; c < 20; c++) begin
      vecs[c].tx        = {2'b01, (c < 10) ? 2'b10 : 2'b01, 2'b01};
      vecs[c].exp_alert = (c == 3) ? 3'b010 : 3'b000;
      vecs[c].exp_fail  = 3'b000;
      vecs[c].exp_ack   = {2'b01, (c >= 3 && c <= 12) ? 2'b10 : 2'b01, 2'b01};
    end
    for (int r = 0; r < 20; r++) begin
      vecs[20+r].tx        = {2'b01, 2'b01, (r <= 3) ? 2'b11 : 2'b01};
      vecs[20+r].exp_alert = 3'b000;
      vecs[20+r].exp_fail  = (r >= 3 && r <= 6) ? 3'b001 : 3'b000;
      vecs[20+r].exp_ack   = idle_ack();
    end

    // 1. reset state
    tx = {N{AlertTxIdle}};
    #3;
    chk("reset_ack_in_reset", rx, idle_ack());
    do_reset();
    chk("reset_ack", rx, idle_ack());
    chk("reset_alert", alert, 0);
    chk("reset_fail", fail, 0);
    chk("reset_cnt", cnt, 0);

    // 2 + 3. table-driven vectors
    for (int i = 0; i < 40; i++) begin
      tick();
      chk($sformatf("vec%0d_alert", i), alert, vecs[i].exp_alert);
      chk($sformatf("vec%0d_fail", i), fail, vecs[i].exp_fail);
      chk($sformatf("vec%0d_ack", i), rx, vecs[i].exp_ack);
      tx = vecs[i].tx;
    end
    chk("t2_cnt1", cnt[1], 1);
    chk("t3_cnt0", cnt[0], 0);
    chk("t2_cnt2", cnt[2], 0);

    // 4. all lanes simultaneously
    do_reset();
    tick();
    tx = {N{2'b10}};
    for (int c = 1; c < 20; c++) begin
      tick();
      chk($sformatf("t4_alert_c%0d", c), alert, (c == 3) ? 3'b111 : 3'b000);
    end
    for (int l = 0; l < N; l++) chk($sformatf("t4_cnt%0d", l), cnt[l], 1);
    tx = {N{AlertTxIdle}};
    repeat (8) tick();

    // 5. saturation on lane2, then clear coinciding with an accept
    for (int h = 0; h < 300; h++) begin
      tx[2] = 2'b10;
      repeat (5) tick();
      tx[2] = 2'b01;
      repeat (5) tick();
    end
    chk("t5_sat", cnt[2], 255);
    tx[2] = 2'b10;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_pulse", alert[2], 1);
    chk("t5_clr_cnt", cnt[2], 0);
    tick();
    chk("t5_after_clr", cnt[2], 0);
    tx[2] = 2'b01;
    repeat (6) tick();

    // 6. reset mid-handshake with sender still asserting
    tx[0] = 2'b10;
    repeat (5) tick();
    chk("t6_hs_ack", rx[0], 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_ack_async", rx[0], 2'b01);
    chk("t6_cnt_async", cnt[0], 0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("t6_alert_c%0d", c), alert[0], (c == 3) ? 1'b1 : 1'b0);
    end
    chk("t6_cnt", cnt[0], 1);

    // Randomized phase against the reference model.
    do_reset();
    for (int l = 0; l < N; l++) begin
      m_phase[l] = 0; m_cnt[l] = 0;
      m_d0[l] = 2'b01; m_d1[l] = 2'b01;
      hold_val[l] = 2'b01; hold_cnt[l] = 0;
    end
    clr_prev = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      model_edge(clr_prev);
      chk("rnd_alert", alert, m_alert);
      chk("rnd_fail", fail, m_fail);
      chk("rnd_ack", rx, m_ack);
      chk("rnd_cnt", cnt, {8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])});
      for (int l = 0; l < N; l++) begin
        if (hold_cnt[l] == 0) begin
          int r;
          r = int'($urandom_range(0, 99));
          hold_val[l] = (r < 40) ? 2'b10 : (r < 88) ? 2'b01 : (r < 94) ? 2'b00 : 2'b11;
          hold_cnt[l] = int'($urandom_range(1, 7));
        end
        tx[l] = hold_val[l];
        hold_cnt[l]--;
      end
      clr = ($urandom_range(0, 99) < 3);
      clr_prev = clr;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
